// File: rtl/seg7_scan_driver_if.sv
// Display-word input and dual-bank 7-segment scan outputs of seg7_scan_driver.
interface seg7_scan_driver_if;
  logic [31:0]     data;
  logic            hex_mode;
  logic            blank;
  logic [1:0][7:0] seg;
  logic [1:0][3:0] seg_sel;
  logic            overflow;

  modport master (output data, hex_mode, blank, input seg, seg_sel, overflow);
  modport slave  (input data, hex_mode, blank, output seg, seg_sel, overflow);
endinterface

// File: rtl/seg7_scan_driver.sv
// Renders a 32-bit word as 8 hex or decimal digits (double-dabble) and scans
// both 4-digit banks in parallel, one position per SCAN_DIV clk_slow cycles.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 4
) (
  input logic                clk_slow,
  input logic                rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {LOAD, CONV, COMMIT} state_t;

  state_t           state, state_next;
  logic [31:0]      sh;
  logic [39:0]      bcd, bcd_adj;
  logic [4:0]       count;
  logic             hex_q;
  logic [7:0]       disp      [8];
  logic [7:0]       disp_next [8];
  logic             ovf_next;
  logic             lead;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'hFC;  4'h1: glyph = 8'h60;  4'h2: glyph = 8'hDA;  4'h3: glyph = 8'hF2;
      4'h4: glyph = 8'h66;  4'h5: glyph = 8'hB6;  4'h6: glyph = 8'hBE;  4'h7: glyph = 8'hE0;
      4'h8: glyph = 8'hFE;  4'h9: glyph = 8'hF6;  4'hA: glyph = 8'hEE;  4'hB: glyph = 8'h3E;
      4'hC: glyph = 8'h9C;  4'hD: glyph = 8'h7A;  4'hE: glyph = 8'h9E;  default: glyph = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk_slow) begin
    if (!rst) state <= LOAD;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    state_next = bus.hex_mode ? COMMIT : CONV;
      CONV:    if (count == 5'd31) state_next = COMMIT;
      COMMIT:  state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < 10; i++)
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  // Leading-zero blanking walks down from digit 7; digit 0 is always shown.
  always_comb begin
    ovf_next = 1'b0;
    lead     = 1'b1;
    for (int unsigned i = 0; i < 8; i++) disp_next[i] = 8'h00;
    if (hex_q) begin
      for (int unsigned i = 0; i < 8; i++) disp_next[i] = glyph(sh[4*i +: 4]);
    end else if (bcd[39:32] != '0) begin
      ovf_next = 1'b1;
      for (int unsigned i = 0; i < 8; i++) disp_next[i] = 8'h02;
    end else begin
      for (int unsigned i = 8; i > 0; i--) begin
        if (lead && (i > 1) && (bcd[4*(i-1) +: 4] == 4'd0)) begin
          disp_next[i-1] = 8'h00;
        end else begin
          lead           = 1'b0;
          disp_next[i-1] = glyph(bcd[4*(i-1) +: 4]);
        end
      end
    end
  end

  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      sh           <= '0;
      bcd          <= '0;
      count        <= '0;
      hex_q        <= 1'b0;
      bus.overflow <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) disp[i] <= 8'h00;
    end else begin
      case (state)
        LOAD: begin
          sh    <= bus.data;
          hex_q <= bus.hex_mode;
          bcd   <= '0;
          count <= '0;
        end
        CONV: begin
          {bcd, sh} <= {bcd_adj, sh} << 1;
          count     <= count + 5'd1;
        end
        COMMIT: begin
          bus.overflow <= ovf_next;
          for (int unsigned i = 0; i < 8; i++) disp[i] <= disp_next[i];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      div         <= '0;
      idx         <= '0;
      bus.seg     <= '0;
      bus.seg_sel <= '0;
    end else begin
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      if (bus.blank) begin
        bus.seg     <= '0;
        bus.seg_sel <= '0;
      end else begin
        bus.seg_sel[0] <= 4'b0001 << idx;
        bus.seg_sel[1] <= 4'b0001 << idx;
        bus.seg[0]     <= disp[{1'b0, idx}];
        bus.seg[1]     <= disp[{1'b1, idx}];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed and random checks of seg7_scan_driver against an arithmetic display model.
module tb_seg7_scan_driver;
  localparam int unsigned SCAN_DIV = 4;

  logic clk_slow = 1'b0;
  logic rst      = 1'b0;
  int unsigned k = 0;
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] gly [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
  logic [7:0] exp_g [8];
  logic       exp_ovf;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk_slow (clk_slow),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_slow = ~clk_slow;

  // Edge count since the last reset release; edge 1 is the first LOAD.
  always @(posedge clk_slow) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  task automatic model(input logic [31:0] v, input logic h);
    longint unsigned p;
    exp_ovf = 1'b0;
    if (h) begin
      for (int i = 0; i < 8; i++) exp_g[i] = gly[(v >> (4*i)) & 32'hF];
    end else if (v > 32'd99999999) begin
      exp_ovf = 1'b1;
      for (int i = 0; i < 8; i++) exp_g[i] = 8'h02;
    end else begin
      p = 1;
      for (int i = 0; i < 8; i++) begin
        exp_g[i] = (i == 0 || longint'(v) >= p) ? gly[(longint'(v) / p) % 10] : 8'h00;
        p = p * 10;
      end
    end
  endtask

  task automatic scan_check(input int cycles, input string tag);
    int unsigned pos;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_slow);
      pos = ((k - 1) / SCAN_DIV) % 4;
      check({tag, "_sel"}, 64'(bus.seg_sel), 64'({2{4'b0001 << pos}}));
      check({tag, "_seg"}, 64'(bus.seg), 64'({exp_g[pos + 4], exp_g[pos]}));
      check({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
    end
  endtask

  task automatic apply(input logic [31:0] v, input logic h, input string tag);
    bus.data     = v;
    bus.hex_mode = h;
    model(v, h);
    repeat (70) @(negedge clk_slow);
    scan_check(16, tag);
  endtask

  initial begin
    bus.data     = 32'hFFFF_FFFF;
    bus.hex_mode = 1'b0;
    bus.blank    = 1'b0;

    // Reset held, then first decimal conversion commits at edge 34.
    repeat (3) @(negedge clk_slow);
    check("rst_seg", 64'(bus.seg), 64'h0);
    check("rst_sel", 64'(bus.seg_sel), 64'h0);
    check("rst_ovf", 64'(bus.overflow), 64'h0);
    rst = 1'b1;
    @(negedge clk_slow);
    check("first_sel", 64'(bus.seg_sel), 64'h11);
    check("first_seg", 64'(bus.seg), 64'h0);
    repeat (32) @(negedge clk_slow);
    check("k33_ovf", 64'(bus.overflow), 64'h0);
    @(negedge clk_slow);
    check("k34_ovf", 64'(bus.overflow), 64'h1);
    check("k34_seg", 64'(bus.seg), 64'h0);
    @(negedge clk_slow);
    check("k35_seg", 64'(bus.seg), 64'h0202);
    model(32'hFFFF_FFFF, 1'b0);
    scan_check(16, "ffff_dec");

    // Abort at CONV cycle 15, then a fresh 34-cycle conversion of 12345.
    bus.data = 32'd12345;
    model(32'd12345, 1'b0);
    rst = 1'b0;
    @(negedge clk_slow);
    rst = 1'b1;
    repeat (16) @(negedge clk_slow);
    rst = 1'b0;
    @(negedge clk_slow);
    check("abort_seg", 64'(bus.seg), 64'h0);
    check("abort_ovf", 64'(bus.overflow), 64'h0);
    rst = 1'b1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk_slow);
      check("abort_blank", 64'(bus.seg), 64'h0);
    end
    @(negedge clk_slow);
    check("commit35", 64'(bus.seg), 64'({exp_g[4], exp_g[0]}));
    scan_check(16, "d12345");

    apply(32'd0,         1'b0, "d0");
    apply(32'd100,       1'b0, "d100");
    apply(32'd100000000, 1'b0, "d1e8");
    apply(32'd99999999,  1'b0, "d99999999");
    apply(32'h1234_ABCD, 1'b1, "h1234abcd");

    // Blank suppresses output without stopping the scan index.
    bus.blank = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_slow);
      check("blank_sel", 64'(bus.seg_sel), 64'h0);
      check("blank_seg", 64'(bus.seg), 64'h0);
    end
    bus.blank = 1'b0;
    scan_check(8, "unblank");

    for (int n = 0; n < 8; n++) begin
      logic [31:0] v;
      logic        h;
      h = 1'($urandom % 2);
      case ($urandom % 3)
        0:       v = $urandom;
        1:       v = $urandom % 100000000;
        default: v = $urandom % 1000;
      endcase
      apply(v, h, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream consumer of the ecall I/O handler's display word: takes a 32-bit value and renders it on the board's two 4-digit 7-segment banks. Converts the value to 8 hex digits or up to 8 unsigned decimal digits using a sequential double-dabble converter. Multiplexes both banks in parallel, one digit position at a time, on the slow clock domain.

## Interface
- SCAN_DIV, 4: clk_slow cycles each digit position is held; must be ≥1.
- clk_slow  in  1  slow clock (from clock divider); all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- data  in  32  value to display; sampled once per conversion; held stable by the producer.
- hex_mode  in  1  1 = hexadecimal, 0 = unsigned decimal; sampled with data.
- blank  in  1  1 = all digit selects off; not latched, applied at the scan output register.
- seg  out  [1:0][7:0]  segment pattern per bank, active-high. Bit7 = a … bit1 = g, bit0 = dp. seg[1] is the left bank (digits 7..4), seg[0] the right bank (digits 3..0).
- seg_sel  out  [1:0][3:0]  one-hot digit select per bank, active-high.
- overflow  out  1  1 while the committed decimal value exceeds 99,999,999.

## Operation
- Conversion FSM has three states: LOAD, CONV and COMMIT.
- **LOAD** (1 cycle):
  - latch data into shift register `sh`; latch hex_mode.
  - clear the 40-bit BCD register (10 digits); clear the iteration count.
  - next state is COMMIT if hex_mode, else CONV.
- **CONV** (32 cycles), each cycle:
  - every BCD digit ≥5 gets +3;
  - then shift {bcd, sh} left by 1.
  - leave after the 32nd shift.
- **COMMIT** (1 cycle): write the 8-entry display register, then go to LOAD.
  - Hex: digit i = sh[4i+3:4i]. All 8 digits shown; no zero suppression.
  - Decimal, BCD digit 9 or 8 nonzero: all 8 digits show dash; overflow=1.
  - Decimal otherwise: digit i = BCD digit i. Leading zeros from digit 7 down to digit 1 become blank; digit 0 is always shown. overflow=0.
  - Hex commit forces overflow=0.
- Refresh period is 34 cycles in decimal and 2 cycles in hex. The FSM free-runs continuously.
- **Scan:**
  - divider counter 0..SCAN_DIV-1; on wrap, idx (0..3) increments mod 4.
  - registered output: seg_sel[b] = 1<<idx; seg[0] = glyph(digit idx); seg[1] = glyph(digit idx+4).
  - blank=1 forces seg_sel=0 and seg=0 on the next edge.
- **Glyphs:**
  - hex digits: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E.
  - dash=02; blank=00.
  - dp is always 0.
- The display register changes only in COMMIT, so the scan never shows a partially converted value.

## Timing
- **Reset** (rst=0 at an edge):
  - state=LOAD, bcd=0, sh=0, count=0;
  - all display entries blank, overflow=0;
  - divider=0, idx=0, seg=0, seg_sel=0.
  - Reset asserted mid-CONV aborts the conversion; the display stays blank.
- **After release:**
  - edge 1 is LOAD;
  - decimal commits at edge 34, hex at edge 2;
  - seg reflects the committed value one edge after commit, at whatever idx is current.
- First seg_sel assertion is at edge 1 after release, with idx=0 and glyph blank (00).
- Data change latency: at most 34 + 34 cycles (decimal) or 2 + 2 (hex) until committed, plus 1 for the scan register.
- Divider and scan run independently of the FSM; a commit during a digit's dwell updates that digit's glyph on the next edge.
- hex_mode changing mid-CONV has no effect until the next LOAD.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with data=0xFFFFFFFF → seg=00, seg_sel=0, overflow=0. Release → decimal first commit at edge 34.
- **Hex:** hex_mode=1, data=0x1234ABCD, SCAN_DIV=4.
  - At idx0: seg_sel[0]=0001, seg[0]=7A (d), seg[1]=66 (4).
  - At idx3: seg_sel=1000, seg[0]=EE (A), seg[1]=60 (1).
  - Each idx is held 4 cycles.
- **Decimal 12345:** digits 0..4 = 5,4,3,2,1 → B6, 66, F2, DA, 60. Digits 5..7 = 00. Committed exactly 34 cycles after LOAD.
- **Decimal 0 and 100:**
  - 0 → digit0=FC, all others blank.
  - 100 → digits 0..2 = FC, FC, 60; digits 3..7 blank.
- **Overflow:**
  - data=100000000 → every digit 02, overflow=1.
  - data=99999999 → every digit F6, overflow=0.
  - data=0xFFFFFFFF → all dashes.
- **Blank and abort:**
  - blank=1 → seg_sel=0, seg=0 one edge later; scan idx keeps advancing.
  - rst pulsed at CONV cycle 15 → display blank; fresh 34-cycle conversion follows.
